// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: per-cycle grant (round-robin or fixed
// priority) with burst lock and a starvation bound, registered RAM command and tagged read return.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] MaxLockC = 8'(MAX_LOCK);

    logic              rr_last_q, rr_last_d;
    logic              lock_vld_q, lock_vld_d;
    logic              lock_id_q, lock_id_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rd_port_q, rd_port_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic              any_req;
    logic              req_own;
    logic              req_oth;
    logic              lock_hold;
    logic              lock_yield;
    logic              sel;
    logic              acc;
    logic              acc_we;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Grant selection
    always_comb begin
        any_req    = req0 | req1;
        req_own    = lock_id_q ? req1 : req0;
        req_oth    = lock_id_q ? req0 : req1;
        lock_hold  = lock_vld_q & req_own & (lock_cnt_q < MaxLockC);
        // Saturated lock with the other port waiting: hand over regardless of priority mode.
        lock_yield = lock_vld_q & req_own & ~lock_hold & req_oth;
        sel        = 1'b0;
        if (lock_hold) begin
            sel = lock_id_q;
        end else if (lock_yield) begin
            sel = ~lock_id_q;
        end else if (req0 & req1) begin
            sel = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last_q;
        end else begin
            sel = req1;
        end
        gnt0 = ~rst & any_req & ~sel;
        gnt1 = ~rst & any_req & sel;
    end

    always_comb begin
        acc       = gnt0 | gnt1;
        acc_we    = sel ? we1 : we0;
        acc_lock  = sel ? lock1 : lock0;
        acc_addr  = sel ? addr1 : addr0;
        acc_wdata = sel ? wdata1 : wdata0;
    end

    // Next-state: RAM command, read tag pipeline, round-robin and lock bookkeeping
    always_comb begin
        ram_en_d    = acc;
        ram_we_d    = acc & acc_we;
        ram_addr_d  = acc ? acc_addr : ram_addr_q;
        ram_wdata_d = acc ? acc_wdata : ram_wdata_q;
        rd_port_d   = acc ? sel : rd_port_q;
        rvalid0_d   = ram_en_q & ~ram_we_q & ~rd_port_q;
        rvalid1_d   = ram_en_q & ~ram_we_q & rd_port_q;
        rr_last_d   = acc ? sel : rr_last_q;
        lock_vld_d  = lock_vld_q;
        lock_id_d   = lock_id_q;
        lock_cnt_d  = lock_cnt_q;
        if (acc) begin
            if (acc_lock) begin
                if (lock_vld_q && (lock_id_q == sel)) begin
                    lock_cnt_d = (lock_cnt_q < MaxLockC) ? lock_cnt_q + 8'd1 : lock_cnt_q;
                end else begin
                    lock_vld_d = 1'b1;
                    lock_id_d  = sel;
                    lock_cnt_d = 8'd1;
                end
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = 8'd0;
            end
        end else if (lock_vld_q && !req_own) begin
            lock_vld_d = 1'b0;
            lock_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rr_last_q   <= 1'b1;
            lock_vld_q  <= 1'b0;
            lock_id_q   <= 1'b0;
            lock_cnt_q  <= 8'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_port_q   <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            lock_vld_q  <= lock_vld_d;
            lock_id_q   <= lock_id_d;
            lock_cnt_q  <= lock_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_port_q   <= rd_port_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    // The RAM's registered output already lines up with rvalid, so rdata is a gated pass-through.
    always_comb begin
        ram_en    = ram_en_q;
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        rvalid0   = rvalid0_q;
        rvalid1   = rvalid1_q;
        rdata     = (rvalid0_q | rvalid1_q) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own synchronous RAM model.
module tb_ram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          gnt0_rr, gnt1_rr, rvalid0_rr, rvalid1_rr, ram_en_rr, ram_we_rr;
    logic [DW-1:0] rdata_rr, ram_wdata_rr, ram_rdata_rr;
    logic [AW-1:0] ram_addr_rr;
    logic          gnt0_fp, gnt1_fp, rvalid0_fp, rvalid1_fp, ram_en_fp, ram_we_fp;
    logic [DW-1:0] rdata_fp, ram_wdata_fp, ram_rdata_fp;
    logic [AW-1:0] ram_addr_fp;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] mem_rr [16];
    logic [DW-1:0] mem_fp [16];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .MAX_LOCK(2)) dut_rr (
        .CLK(CLK), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0_rr), .gnt1(gnt1_rr),
        .rvalid0(rvalid0_rr), .rvalid1(rvalid1_rr), .rdata(rdata_rr),
        .ram_en(ram_en_rr), .ram_we(ram_we_rr), .ram_addr(ram_addr_rr),
        .ram_wdata(ram_wdata_rr), .ram_rdata(ram_rdata_rr)
    );

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .MAX_LOCK(2)) dut_fp (
        .CLK(CLK), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0_fp), .gnt1(gnt1_fp),
        .rvalid0(rvalid0_fp), .rvalid1(rvalid1_fp), .rdata(rdata_fp),
        .ram_en(ram_en_fp), .ram_we(ram_we_fp), .ram_addr(ram_addr_fp),
        .ram_wdata(ram_wdata_fp), .ram_rdata(ram_rdata_fp)
    );

    always @(posedge CLK) begin
        if (bd_we) begin
            mem_rr[bd_addr] <= bd_data;
            mem_fp[bd_addr] <= bd_data;
        end else begin
            if (ram_en_rr && ram_we_rr) mem_rr[ram_addr_rr] <= ram_wdata_rr;
            if (ram_en_fp && ram_we_fp) mem_fp[ram_addr_fp] <= ram_wdata_fp;
        end
        if (ram_en_rr && !ram_we_rr) ram_rdata_rr <= mem_rr[ram_addr_rr];
        if (ram_en_fp && !ram_we_fp) ram_rdata_fp <= mem_fp[ram_addr_fp];
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        next_cycle();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); req0 = 1'b1; req1 = 1'b1;
        #1;
        checks++; if (gnt0_rr !== 1'b0 || gnt1_rr !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt0_rr, gnt1_rr); end
        next_cycle();
        checks++; if (ram_en_rr !== 1'b0 || ram_we_rr !== 1'b0) begin
            errors++; $display("FAIL reset_ram_cmd: got en=%b we=%b want 0 0", ram_en_rr, ram_we_rr); end
        checks++; if (ram_addr_rr !== 4'h0 || ram_wdata_rr !== 8'h00) begin
            errors++; $display("FAIL reset_ram_addr: got %h/%h want 0/00", ram_addr_rr, ram_wdata_rr); end
        checks++; if (rvalid0_rr !== 1'b0 || rvalid1_rr !== 1'b0 || rdata_rr !== 8'h00) begin
            errors++; $display("FAIL reset_rvalid: got %b%b %h want 00 00", rvalid0_rr, rvalid1_rr, rdata_rr); end
        rst = 1'b0; idle();
        next_cycle();
    endtask

    task automatic test_single_read();
        backdoor(4'd10, 8'h01);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd10;
        #1;
        checks++; if (gnt0_rr !== 1'b1 || gnt1_rr !== 1'b0) begin
            errors++; $display("FAIL single_gnt: got %b%b want 10", gnt0_rr, gnt1_rr); end
        next_cycle();
        idle(); #1;
        checks++; if (ram_en_rr !== 1'b1 || ram_we_rr !== 1'b0 || ram_addr_rr !== 4'd10) begin
            errors++; $display("FAIL single_cmd: got en=%b we=%b a=%0d want 1 0 10", ram_en_rr, ram_we_rr, ram_addr_rr); end
        checks++; if (rvalid0_rr !== 1'b0) begin
            errors++; $display("FAIL single_early_rvalid: got %b want 0", rvalid0_rr); end
        next_cycle();
        checks++; if (rvalid0_rr !== 1'b1 || rvalid1_rr !== 1'b0 || rdata_rr !== 8'h01) begin
            errors++; $display("FAIL single_rdata: got v=%b%b d=%h want 10 01", rvalid0_rr, rvalid1_rr, rdata_rr); end
        next_cycle();
        checks++; if (rvalid0_rr !== 1'b0) begin
            errors++; $display("FAIL single_pulse: got %b want 0", rvalid0_rr); end
    endtask

    task automatic test_round_robin();
        logic e, p;
        backdoor(4'd4, 8'hA4);
        backdoor(4'd5, 8'hB5);
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req0 = (c < 6); req1 = (c < 6); we0 = 1'b0; we1 = 1'b0; addr0 = 4'd4; addr1 = 4'd5;
            #1;
            if (c < 6) begin
                e = 1'(c % 2);
                checks++; if (gnt0_rr !== ~e || gnt1_rr !== e) begin
                    errors++; $display("FAIL rr_gnt c%0d: got %b%b want %b%b", c, gnt0_rr, gnt1_rr, ~e, e); end
            end
            if (c >= 2) begin
                p = 1'((c - 2) % 2);
                checks++; if (rvalid0_rr !== ~p || rvalid1_rr !== p || rdata_rr !== (p ? 8'hB5 : 8'hA4)) begin
                    errors++; $display("FAIL rr_ret c%0d: got v=%b%b d=%h want %b%b %h", c, rvalid0_rr,
                                       rvalid1_rr, rdata_rr, ~p, p, (p ? 8'hB5 : 8'hA4)); end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_loader_burst();
        do_reset();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 4'd0; wdata1 = 8'h1A;
        #1;
        checks++; if (gnt1_rr !== 1'b1 || gnt0_rr !== 1'b0) begin
            errors++; $display("FAIL burst_c0: got %b%b want 01", gnt0_rr, gnt1_rr); end
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7; addr1 = 4'd1; wdata1 = 8'h2B;
        #1;
        checks++; if (gnt1_rr !== 1'b1 || gnt0_rr !== 1'b0) begin
            errors++; $display("FAIL burst_c1: got %b%b want 01", gnt0_rr, gnt1_rr); end
        next_cycle();
        addr1 = 4'd2; wdata1 = 8'h4C;
        #1;
        checks++; if (gnt0_rr !== 1'b1 || gnt1_rr !== 1'b0) begin
            errors++; $display("FAIL burst_c2_starve: got %b%b want 10", gnt0_rr, gnt1_rr); end
        next_cycle();
        req0 = 1'b0;
        #1;
        checks++; if (gnt1_rr !== 1'b1 || ram_addr_rr !== 4'd7 || ram_we_rr !== 1'b0) begin
            errors++; $display("FAIL burst_c3: got g1=%b a=%0d we=%b want 1 7 0", gnt1_rr, ram_addr_rr, ram_we_rr); end
        next_cycle();
        idle(); #1;
        checks++; if (ram_addr_rr !== 4'd2 || ram_we_rr !== 1'b1 || ram_wdata_rr !== 8'h4C || rvalid0_rr !== 1'b1) begin
            errors++; $display("FAIL burst_c4: got a=%0d we=%b d=%h rv0=%b want 2 1 4c 1", ram_addr_rr,
                               ram_we_rr, ram_wdata_rr, rvalid0_rr); end
        next_cycle();
        checks++; if (mem_rr[0] !== 8'h1A || mem_rr[1] !== 8'h2B || mem_rr[2] !== 8'h4C) begin
            errors++; $display("FAIL burst_mem: got %h %h %h want 1a 2b 4c", mem_rr[0], mem_rr[1], mem_rr[2]); end
        next_cycle();
    endtask

    task automatic test_write_then_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd12; wdata1 = 8'h55;
        #1;
        checks++; if (gnt1_rr !== 1'b1) begin
            errors++; $display("FAIL wr_gnt: got %b want 1", gnt1_rr); end
        next_cycle();
        idle(); req0 = 1'b1; addr0 = 4'd12;
        #1;
        checks++; if (gnt0_rr !== 1'b1) begin
            errors++; $display("FAIL rd_gnt: got %b want 1", gnt0_rr); end
        next_cycle();
        idle();
        next_cycle();
        checks++; if (rvalid0_rr !== 1'b1 || rvalid1_rr !== 1'b0 || rdata_rr !== 8'h55) begin
            errors++; $display("FAIL wr_rd_data: got v=%b%b d=%h want 10 55", rvalid0_rr, rvalid1_rr, rdata_rr); end
        next_cycle();
    endtask

    task automatic test_fixed_prio();
        for (int c = 0; c < 6; c++) begin
            req0 = (c < 5); req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd10; addr1 = 4'd10;
            #1;
            checks++; if (gnt0_fp !== (c < 5) || gnt1_fp !== (c >= 5)) begin
                errors++; $display("FAIL fp_gnt c%0d: got %b%b want %b%b", c, gnt0_fp, gnt1_fp, (c < 5), (c >= 5)); end
            if (c >= 2) begin
                checks++; if (rvalid0_fp !== 1'b1 || rvalid1_fp !== 1'b0 || rdata_fp !== 8'h01) begin
                    errors++; $display("FAIL fp_ret c%0d: got v=%b%b d=%h want 10 01", c, rvalid0_fp,
                                       rvalid1_fp, rdata_fp); end
            end
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 4'd10;
        #1;
        checks++; if (gnt1_rr !== 1'b1) begin
            errors++; $display("FAIL mid_gnt: got %b want 1", gnt1_rr); end
        next_cycle();
        rst = 1'b1; req0 = 1'b1;
        #1;
        checks++; if (gnt0_rr !== 1'b0 || gnt1_rr !== 1'b0) begin
            errors++; $display("FAIL mid_rst_gnt: got %b%b want 00", gnt0_rr, gnt1_rr); end
        next_cycle();
        rst = 1'b0; idle(); req0 = 1'b1; req1 = 1'b1; addr0 = 4'd10; addr1 = 4'd10;
        #1;
        checks++; if (rvalid0_rr !== 1'b0 || rvalid1_rr !== 1'b0 || rdata_rr !== 8'h00 || ram_en_rr !== 1'b0) begin
            errors++; $display("FAIL mid_no_rvalid: got v=%b%b d=%h en=%b want 00 00 0", rvalid0_rr,
                               rvalid1_rr, rdata_rr, ram_en_rr); end
        checks++; if (ram_addr_rr !== 4'd0 || ram_we_rr !== 1'b0) begin
            errors++; $display("FAIL mid_ram_regs: got a=%0d we=%b want 0 0", ram_addr_rr, ram_we_rr); end
        checks++; if (gnt0_rr !== 1'b1 || gnt1_rr !== 1'b0) begin
            errors++; $display("FAIL mid_first_tie: got %b%b want 10", gnt0_rr, gnt1_rr); end
        next_cycle();
        idle();
        next_cycle();
        checks++; if (rvalid0_rr !== 1'b1 || rvalid1_rr !== 1'b0 || rdata_rr !== 8'h01) begin
            errors++; $display("FAIL mid_after: got v=%b%b d=%h want 10 01", rvalid0_rr, rvalid1_rr, rdata_rr); end
        next_cycle();
    endtask

    initial begin
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        rst = 1'b1;
        idle();
        next_cycle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_loader_burst();
        test_write_then_read();
        test_fixed_prio();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
